game_ctrl: RTL and testbench

- Game-flow sequencer for the crossyroad VGA game.
- Sits between the VGA timing/pixel-compare logic and the scroll_v/scroll_h obstacle movers.
- Debounces the move button on frame boundaries and turns pixel-level chicken/obstacle overlap into frame-level hit events.
- Runs an IDLE/PLAY/HIT/OVER state machine; issues game-restart pulses, per-move pulses, freeze, score and lives to the datapath and display.

---
 rtl/game_ctrl_pkg.sv | 19 +
 rtl/game_ctrl_frame_debounce.sv | 57 +++++
 rtl/game_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// game_pkg: shared definitions for the crossyroad game-flow sequencer.
//   - game_state_t : IDLE/PLAY/HIT/OVER encoding, also used by the top-level
//                    rgb selection (which colours to draw by state/flash).
//   - DEF_*        : default values for the game_ctrl parameters.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam int DEF_SCORE_W         = 8;
    localparam int DEF_LIVES           = 3;
    localparam int DEF_HIT_FRAMES      = 60;
    localparam int DEF_DEBOUNCE_FRAMES = 2;

endpackage

// File: rtl/game_ctrl_frame_debounce.sv
// frame_debounce: move-button conditioning on frame boundaries.
//   The raw button is brought in through a 2-FF synchronizer. The synchronized
//   level is sampled only on frame_tick into a saturating 4-bit run counter.
//   A press is accepted on the frame_tick where the run reaches
//   DEBOUNCE_FRAMES while armed; a low sample clears the run and re-arms, so a
//   held button yields exactly one press.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   frame_tick    : one-clk pulse per frame
//   move_btn      : raw asynchronous button
//   press_accept  : high during the frame_tick cycle that accepts a press, so
//                   the registered game state reacts at frame_tick+1
module frame_debounce #(
    parameter int DEBOUNCE_FRAMES = 2
)(
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic move_btn,
    output logic press_accept
);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] run_cnt;
    logic       fired;     // 1 = press already taken for this run (disarmed)

    // Accept when this sample takes the run from DEBOUNCE_FRAMES-1 to DEBOUNCE_FRAMES.
    assign press_accept = frame_tick && sync_p1 && !fired &&
                          (run_cnt == 4'(DEBOUNCE_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            run_cnt <= 4'd0;
            fired   <= 1'b0;
        end else begin
            // synchronizer stage boundary
            sync_p0 <= move_btn;
            sync_p1 <= sync_p0;
            // frame-sampled run counter
            if (frame_tick) begin
                if (sync_p1) begin
                    if (run_cnt != 4'd15)
                        run_cnt <= run_cnt + 4'd1;
                    if (press_accept)
                        fired <= 1'b1;
                end else begin
                    run_cnt <= 4'd0;
                    fired   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-flow sequencer for the crossyroad VGA game.
//   IDLE/PLAY/HIT/OVER state machine advanced only on frame boundaries.
//   Turns pixel-level chicken/obstacle overlap into one hit per frame, and
//   debounced button presses into game starts or moves.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   frame_tick  : one-clk pulse at start of vertical blank
//   move_btn    : raw button
//   collision   : per-pixel chicken AND obstacle overlap
//   game_rst    : one-clk pulse, restart obstacle positions
//   move_pulse  : one-clk pulse per accepted move in PLAY
//   freeze      : obstacles hold position (every state except PLAY)
//   flash       : display blink control
//   state       : IDLE=0 PLAY=1 HIT=2 OVER=3
//   score       : moves this game, saturating
//   lives       : remaining lives
//   hiscore     : best score so far (only with GAME_CTRL_HISCORE_EN)
// Build option: define GAME_CTRL_HISCORE_EN to add the high-score register.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES           = DEF_LIVES,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int HIT_FRAMES      = DEF_HIT_FRAMES,
    parameter int SCORE_W         = DEF_SCORE_W
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               move_btn,
    input  logic               collision,
    output logic               game_rst,
    output logic               move_pulse,
    output logic               freeze,
    output logic               flash,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives
`ifdef GAME_CTRL_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hiscore
`endif
);

    game_state_t        st_q, st_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic [2:0]         lives_nxt;
    logic [7:0]         cnt_q, cnt_nxt;    // frames spent in HIT / OVER
    logic               game_rst_nxt;
    logic               move_pulse_nxt;
    logic               flash_nxt;
    logic               hit_latch;
    logic               hit_now;
    logic               press_accept;

    assign state = st_q;

    frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .move_btn     (move_btn),
        .press_accept (press_accept)
    );

    // A collision in the frame_tick cycle itself still belongs to this frame.
    assign hit_now = hit_latch || collision;

`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_nxt;
    logic               new_hi_q, new_hi_nxt;
`endif

    always_comb begin
        st_nxt         = st_q;
        score_nxt      = score;
        lives_nxt      = lives;
        cnt_nxt        = cnt_q;
        game_rst_nxt   = 1'b0;
        move_pulse_nxt = 1'b0;
        if (frame_tick) begin
            unique case (st_q)
                ST_IDLE: begin
                    if (press_accept) begin
                        st_nxt       = ST_PLAY;
                        score_nxt    = '0;
                        lives_nxt    = 3'(LIVES);
                        game_rst_nxt = 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Hit wins over a press in the same frame.
                    if (hit_now) begin
                        st_nxt    = ST_HIT;
                        lives_nxt = lives - 3'd1;
                        cnt_nxt   = 8'd0;
                    end else if (press_accept) begin
                        move_pulse_nxt = 1'b1;
                        if (score != {SCORE_W{1'b1}})
                            score_nxt = score + 1'b1;
                    end
                end
                ST_HIT: begin
                    if (cnt_q == 8'(HIT_FRAMES - 1)) begin
                        cnt_nxt = 8'd0;
                        if (lives != 3'd0) begin
                            st_nxt       = ST_PLAY;
                            game_rst_nxt = 1'b1;
                        end else begin
                            st_nxt = ST_OVER;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 8'd1;
                    end
                end
                ST_OVER: begin
                    if (press_accept) begin
                        st_nxt       = ST_PLAY;
                        score_nxt    = '0;
                        lives_nxt    = 3'(LIVES);
                        game_rst_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 8'd1;
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end

`ifdef GAME_CTRL_HISCORE_EN
        hiscore_nxt = hiscore;
        new_hi_nxt  = new_hi_q;
        if (st_nxt == ST_OVER && st_q != ST_OVER) begin
            new_hi_nxt = (score > hiscore);
            if (score > hiscore)
                hiscore_nxt = score;
        end
`endif

        flash_nxt = 1'b0;
        if (st_nxt == ST_HIT) begin
            flash_nxt = cnt_nxt[3];
        end else if (st_nxt == ST_OVER) begin
`ifdef GAME_CTRL_HISCORE_EN
            flash_nxt = new_hi_nxt ? cnt_nxt[4] : 1'b1;
`else
            flash_nxt = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            score      <= '0;
            lives      <= 3'(LIVES);
            cnt_q      <= 8'd0;
            hit_latch  <= 1'b0;
            game_rst   <= 1'b0;
            move_pulse <= 1'b0;
            freeze     <= 1'b1;
            flash      <= 1'b0;
        end else begin
            st_q       <= st_nxt;
            score      <= score_nxt;
            lives      <= lives_nxt;
            cnt_q      <= cnt_nxt;
            game_rst   <= game_rst_nxt;
            move_pulse <= move_pulse_nxt;
            freeze     <= (st_nxt != ST_PLAY);
            flash      <= flash_nxt;
            // Latch collects overlap for the current frame; consumed at frame_tick.
            if (st_q != ST_PLAY || frame_tick)
                hit_latch <= 1'b0;
            else if (collision)
                hit_latch <= 1'b1;
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore  <= '0;
            new_hi_q <= 1'b0;
        end else begin
            hiscore  <= hiscore_nxt;
            new_hi_q <= new_hi_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl (default build): frame-level behavioural model plus
// directed scenarios, randomized play and literal expectations.
module tb_game_ctrl;

    localparam int LIVES = 3;
    localparam int DB    = 2;
    localparam int HF    = 60;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_HIT  = 2;
    localparam int S_OVER = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_btn = 1'b0;
    logic       collision = 1'b0;
    logic       game_rst, move_pulse, freeze, flash;
    logic [1:0] st;
    logic [7:0] score;
    logic [2:0] lives;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;
    int grst_cnt = 0;
    int move_cnt = 0;

    // model state
    int m_state, m_score, m_lives, m_hcnt, m_run;
    bit m_grst, m_move, m_pend, m_armed, p1, p2;

    game_ctrl #(
        .LIVES(LIVES), .DEBOUNCE_FRAMES(DB), .HIT_FRAMES(HF), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .move_btn(move_btn),
        .collision(collision), .game_rst(game_rst), .move_pulse(move_pulse),
        .freeze(freeze), .flash(flash), .state(st), .score(score), .lives(lives)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Frame generator: ticks every 8..14 clocks.
    initial begin
        forever begin
            repeat ($urandom_range(7, 13)) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    end

    // Behavioural model: everything happens per frame; pulses last one clock.
    initial begin
        bit seen, pressed, hit;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = S_IDLE; m_score = 0; m_lives = LIVES; m_hcnt = 0;
                m_grst = 0; m_move = 0; m_pend = 0; m_run = 0; m_armed = 1;
                p1 = 0; p2 = 0;
            end else begin
                // button is seen two clocks late
                seen = p2; p2 = p1; p1 = move_btn;
                m_grst = 0; m_move = 0;
                if (frame_tick) begin
                    pressed = 0;
                    if (seen) begin
                        if (m_run < 15) m_run++;
                        if (m_run == DB && m_armed) begin pressed = 1; m_armed = 0; end
                    end else begin
                        m_run = 0; m_armed = 1;
                    end
                    hit = (m_state == S_PLAY) && (m_pend || collision);
                    m_pend = 0;
                    case (m_state)
                        S_IDLE, S_OVER:
                            if (pressed) begin
                                m_state = S_PLAY; m_score = 0; m_lives = LIVES; m_grst = 1;
                            end
                        S_PLAY:
                            if (hit) begin
                                m_state = S_HIT; m_lives--; m_hcnt = 0;
                            end else if (pressed) begin
                                m_move = 1;
                                if (m_score < 255) m_score++;
                            end
                        default: begin
                            m_hcnt++;
                            if (m_hcnt == HF) begin
                                m_hcnt = 0;
                                if (m_lives > 0) begin m_state = S_PLAY; m_grst = 1; end
                                else m_state = S_OVER;
                            end
                        end
                    endcase
                end else if (m_state == S_PLAY && collision) begin
                    m_pend = 1;
                end
            end
        end
    end

    // Compare process: every clock, shortly after the edge.
    initial begin
        int exp_flash;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                exp_flash = (m_state == S_HIT) ? ((m_hcnt >> 3) & 1) :
                            (m_state == S_OVER) ? 1 : 0;
                chk("state", st, m_state);
                chk("score", score, m_score);
                chk("lives", lives, m_lives);
                chk("game_rst", game_rst, m_grst);
                chk("move_pulse", move_pulse, m_move);
                chk("freeze", freeze, (m_state != S_PLAY) ? 1 : 0);
                chk("flash", flash, exp_flash);
                if (game_rst)   grst_cnt++;
                if (move_pulse) move_cnt++;
            end
        end
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!frame_tick);
        end
        @(negedge clk);
    endtask

    task automatic press(input int hold);
        move_btn = 1'b1;
        wait_frames(hold);
        move_btn = 1'b0;
        wait_frames(1);
    endtask

    task automatic bump();
        repeat (2) @(negedge clk);
        collision = 1'b1;
        repeat (4) @(negedge clk);
        collision = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int g0, m0;
        bit tick_seen;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_state", st, 0);
        chk("reset_lives", lives, 3);
        chk("reset_freeze", freeze, 1);
        chk("reset_flash", flash, 0);
        rst_n = 1'b1;
        wait_frames(1);

        // start: press held 3 frames
        press(3);
        chk("start_state", st, 1);
        chk("start_score", score, 0);
        chk("start_lives", lives, 3);
        chk("start_freeze", freeze, 0);
        chk("start_grst_count", grst_cnt, 1);

        // one-frame press: ignored; long press: exactly one move
        press(1);
        chk("short_press_moves", move_cnt, 0);
        press(10);
        chk("long_press_moves", move_cnt, 1);
        chk("long_press_score", score, 1);

        // first hit
        bump();
        wait_frames(1);
        chk("hit1_state", st, 2);
        chk("hit1_lives", lives, 2);
        chk("hit1_freeze", freeze, 1);
        wait_frames(HF);
        chk("resume_state", st, 1);
        chk("resume_score", score, 1);
        chk("resume_grst_count", grst_cnt, 2);

        // hit and press in the same frame: hit wins
        move_btn = 1'b1;
        wait_frames(1);
        bump();
        wait_frames(1);
        chk("hitpress_state", st, 2);
        chk("hitpress_score", score, 1);
        chk("hitpress_moves", move_cnt, 1);
        move_btn = 1'b0;
        wait_frames(HF);

        // third hit -> OVER
        bump();
        wait_frames(1);
        chk("hit3_lives", lives, 0);
        wait_frames(HF);
        chk("over_state", st, 3);
        chk("over_flash", flash, 1);
        g0 = grst_cnt;
        press(3);
        chk("restart_state", st, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_grst", grst_cnt - g0, 1);

        // randomized play
        repeat (300) begin
            move_btn = 1'($urandom_range(0, 1));
            tick_seen = 0;
            while (!tick_seen) begin
                collision = ($urandom_range(0, 40) == 0);
                @(posedge clk);
                tick_seen = frame_tick;
                @(negedge clk);
            end
        end
        collision = 1'b0;
        move_btn  = 1'b0;

        // score saturation
        do_reset();
        wait_frames(1);
        press(3);
        m0 = move_cnt;
        repeat (256) press(2);
        chk("sat_moves", move_cnt - m0, 256);
        chk("sat_score", score, 255);
        chk("sat_state", st, 1);

        // reset in the middle of HIT
        bump();
        wait_frames(5);
        chk("midhit_state", st, 2);
        rst_n = 1'b0;
        #1;
        chk("async_state", st, 0);
        chk("async_score", score, 0);
        chk("async_lives", lives, 3);
        chk("async_freeze", freeze, 1);
        chk("async_flash", flash, 0);
        chk("async_grst", game_rst, 0);
        chk("async_move", move_pulse, 0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
